// File: rtl/smart_camera.sv
// smart_camera: four-position pan controller that steps toward motion or remote presses
// and drifts back to a home angle after a programmable dwell.
module smart_camera #(
  parameter int         HOLD_CYCLES = 8,
  parameter int         STEP_CYCLES = 2,
  parameter logic [1:0] HOME_ANGLE  = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motion_detected,
  input  logic       remote_control,
  output logic [1:0] camera_angle
);
  localparam int MAXC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, TRACK, RETURN} state_t;
  state_t          state_q, state_d;
  logic [1:0]      angle_q, angle_d;
  logic [CW-1:0]   hold_q, hold_d, step_q, step_d;
  logic            motion_q, remote_q;
  logic            motion_ev, remote_ev;
  assign motion_ev    = motion_detected && !motion_q;
  assign remote_ev    = remote_control && !remote_q;
  assign camera_angle = angle_q;
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    hold_d  = hold_q;
    step_d  = step_q;
    if (remote_ev || motion_ev) begin
      // Remote wins a tie and wraps; motion alone saturates at far right.
      angle_d = remote_ev ? angle_q + 2'd1 : (angle_q == 2'd3 ? 2'd3 : angle_q + 2'd1);
      hold_d  = CW'(HOLD_CYCLES);
      state_d = TRACK;
    end else if (state_q == TRACK) begin
      if (hold_q == CW'(1)) begin
        state_d = (angle_q == HOME_ANGLE) ? IDLE : RETURN;
        step_d  = CW'(STEP_CYCLES);
      end else begin
        hold_d = hold_q - CW'(1);
      end
    end else if (state_q == RETURN) begin
      if (step_q == CW'(1)) begin
        angle_d = (angle_q > HOME_ANGLE) ? angle_q - 2'd1 : angle_q + 2'd1;
        step_d  = CW'(STEP_CYCLES);
        state_d = (angle_d == HOME_ANGLE) ? IDLE : RETURN;
      end else begin
        step_d = step_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      angle_q  <= HOME_ANGLE;
      hold_q   <= '0;
      step_q   <= '0;
      motion_q <= 1'b0;
      remote_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      motion_q <= motion_detected;
      remote_q <= remote_control;
    end
  end
endmodule

// File: tb/tb_smart_camera.sv
// tb_smart_camera: scoreboard bench; expected angles are queued as each cycle is driven
// and popped when the post-edge output is sampled.
module tb_smart_camera;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       motion_detected = 1'b0;
  logic       remote_control = 1'b0;
  logic [1:0] camera_angle;
  logic [1:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  smart_camera dut (
    .clk(clk),
    .rst(rst),
    .motion_detected(motion_detected),
    .remote_control(remote_control),
    .camera_angle(camera_angle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: camera_angle=%0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic m, input logic r, input logic [1:0] e, input string tag);
    @(negedge clk);
    rst = rn;
    motion_detected = m;
    remote_control = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, camera_angle, exp_q.pop_front());
  endtask

  task automatic pulse(input logic m, input logic r, input logic [1:0] e, input string tag);
    cyc(1'b1, m, r, e, tag);
    cyc(1'b1, 1'b0, 1'b0, e, tag);
  endtask

  // Angle k edges after the last event from angle a with default timing (home 0):
  // dwell through +9, then one step down at +10, +12, +14.
  task automatic tail(input logic [1:0] a, input int from, input int n, input string tag);
    for (int k = from; k < from + n; k++) begin
      int s;
      s = (k >= 10) ? (k - 8) / 2 : 0;
      cyc(1'b1, 1'b0, 1'b0, (int'(a) > s) ? 2'(int'(a) - s) : 2'd0, tag);
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 2'd0, "reset");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, "idle_after_reset");

    cyc(1'b1, 1'b1, 1'b0, 2'd1, "motion_edge");
    tail(2'd1, 1, 14, "motion_single_tail");

    cyc(1'b0, 1'b0, 1'b0, 2'd0, "reset2");
    pulse(1'b0, 1'b1, 2'd1, "remote_1");
    pulse(1'b0, 1'b1, 2'd2, "remote_2");
    pulse(1'b0, 1'b1, 2'd3, "remote_3");
    cyc(1'b1, 1'b0, 1'b1, 2'd0, "remote_wrap");
    tail(2'd0, 1, 16, "home_no_move");

    cyc(1'b0, 1'b0, 1'b0, 2'd0, "reset3");
    pulse(1'b1, 1'b0, 2'd1, "motion_1");
    pulse(1'b1, 1'b0, 2'd2, "motion_2");
    pulse(1'b1, 1'b0, 2'd3, "motion_3");
    cyc(1'b1, 1'b1, 1'b0, 2'd3, "motion_sat");
    tail(2'd3, 1, 18, "sat_return");

    cyc(1'b0, 1'b0, 1'b0, 2'd0, "reset4");
    cyc(1'b1, 1'b1, 1'b0, 2'd1, "hold_edge");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 2'd1, "hold_level");
    cyc(1'b1, 1'b0, 1'b0, 2'd1, "hold_release");
    cyc(1'b1, 1'b1, 1'b1, 2'd2, "simultaneous");
    tail(2'd2, 1, 15, "simul_return");

    cyc(1'b0, 1'b0, 1'b0, 2'd0, "reset5");
    pulse(1'b1, 1'b0, 2'd1, "mid_1");
    pulse(1'b1, 1'b0, 2'd2, "mid_2");
    cyc(1'b1, 1'b1, 1'b0, 2'd3, "mid_3");
    tail(2'd3, 1, 10, "mid_return");
    cyc(1'b0, 1'b0, 1'b0, 2'd0, "mid_reset");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, "after_mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/smart_camera.md
Name: smart_camera

Overview:
- Pan-position controller for a home-automation security camera with four discrete pan angles.
- Steps the angle toward activity on a motion-sensor pulse and steps it manually on a remote-control press.
- Holds the new position for a programmable dwell time, then automatically steps back to a home angle.
- Sits between the sensor/remote input conditioning and the pan-motor driver. The output is a registered 2-bit position code.

Parameters:
- HOLD_CYCLES, 8, clock cycles the camera dwells after the last event before returning home (≥1).
- STEP_CYCLES, 2, clock cycles per one-step move during return-to-home (≥1).
- HOME_ANGLE, 2'd0, rest position loaded at reset and targeted by return-to-home.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low: sampled on clk rising edge, reset when 0.
- motion_detected  input  1  motion sensor level; synchronous to clk.
- remote_control  input  1  remote button level; synchronous to clk.
- camera_angle  output  2  registered pan position: 0=far left, 1=left-centre, 2=right-centre, 3=far right.

Behaviour:
- Reset (rst=0 at a rising edge):
  - camera_angle=HOME_ANGLE; state=IDLE.
  - Edge-detect history registers=0; hold and step counters=0.
  - Reset has priority over all events, in any state, including mid-TRACK and mid-RETURN.
- Edge detection:
  - A registered copy of each input is kept.
  - An event is input=1 while the stored previous value is 0.
  - A level held high produces exactly one event.
  - Events are evaluated and acted on in the same rising edge, so the new camera_angle is visible immediately after the edge that samples the input's first high value.
- Remote event:
  - camera_angle <= camera_angle+1, modulo 4 (3 wraps to 0).
  - Load hold counter with HOLD_CYCLES; state <= TRACK.
- Motion event:
  - camera_angle <= camera_angle+1, saturating at 3 (no wrap).
  - Load hold counter with HOLD_CYCLES; state <= TRACK. The counter is reloaded even when the angle is saturated.
- Simultaneous remote and motion events on one edge: only the remote event is applied (single +1 with wrap).
- Event handling is identical in IDLE, TRACK and RETURN. An event during RETURN aborts the return.
- State machine:
  - IDLE: camera_angle is stable at its current value; waits for an event.
  - TRACK: on each edge without an event, if hold counter==1 go to RETURN and load step counter with STEP_CYCLES; otherwise decrement the hold counter. The angle is unchanged throughout TRACK.
  - RETURN: on each edge without an event, if step counter==1 move camera_angle one step toward HOME_ANGLE (decrement if above, increment if below) and reload STEP_CYCLES; otherwise decrement the step counter.
  - RETURN exits to IDLE on the edge where camera_angle equals HOME_ANGLE after the update. If camera_angle already equals HOME_ANGLE on entry, go straight to IDLE.
- camera_angle never changes except on reset, an event, or a RETURN step.
- Counter width: sized to hold max(HOLD_CYCLES, STEP_CYCLES).

Test Plan:
- Reset: hold rst=0 for 1 cycle with both inputs 0 → camera_angle=0 and stays 0 for 20 idle cycles after rst=1.
- Single motion pulse (1 cycle high, defaults) at edge E → camera_angle=1 from E through E+9, then 0 from E+10 onward.
- Four remote pulses, 1 cycle high and 2 cycles apart, from reset → camera_angle sequence 1,2,3,0 (wrap). Then verify auto-return timing from angle 0 is immediate IDLE (no change).
- Four motion pulses, 2 cycles apart → angle 1,2,3,3 (saturation). After the last pulse, angle stays 3 for 8 cycles, then steps 2,1,0 at 2-cycle intervals.
- motion_detected held high 6 cycles, then remote_control and motion_detected rising on the same edge (after both low) → first hold gives exactly one +1; the simultaneous edge gives exactly one further +1.
- Reset mid-operation: pulse motion three times to reach angle 3, wait until RETURN has moved to 2, assert rst=0 for one edge → camera_angle=0 on that edge, and no further movement afterwards.
